// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared event type and helpers for the keypad matrix scanner.
// Build option: KEYPAD_RELEASE_EN (see keypad_matrix_scanner.sv).
package keypad_pkg;

  localparam int MAX_CODE_W = 8;

  typedef struct packed {
    logic [MAX_CODE_W-1:0] code;
    logic                  isRelease;
  } keyEvt_t;

  function automatic int keyIdxWidth(input int rows, input int cols);
    return (rows * cols > 2) ? $clog2(rows * cols) : 1;
  endfunction

  // One-cold row drive pattern; callers keep the low ROWS bits.
  function automatic logic [31:0] rowMask(input int row);
    return ~(32'd1 << row);
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Valid/ready key-event channel between the keypad scanner and the game FSM.
interface keypad_matrix_scanner_if #(
  parameter int CODE_W = 4
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_release;

  modport master (output evt_valid, output evt_code, output evt_release, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_release, output evt_ready);
endinterface

// File: rtl/keypad_matrix_scanner_fifo.sv
// Small valid/ready event FIFO; a push into a full FIFO is still taken when a
// pop happens in the same cycle, otherwise it is dropped and overflow sticks.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  keyEvt_t data_i,
  input  logic    pop_i,
  output logic    valid_o,
  output logic    full_o,
  output keyEvt_t head_o,
  output logic    overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  keyEvt_t          mem_q [DEPTH];
  keyEvt_t          hold_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             doPush;
  logic             doPop;

  assign valid_o    = (count_q != '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign doPop      = pop_i && valid_o;
  assign doPush     = push_i && (!full_o || doPop);
  assign overflow_o = overflow_q;
  // When empty the outputs keep showing the last entry that was consumed.
  assign head_o     = valid_o ? mem_q[rdPtr_q] : hold_q;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr_q <= (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
        hold_q  <= mem_q[rdPtr_q];
      end
      if (doPush && !doPop) begin
        count_q <= count_q + 1'b1;
      end else if (doPop && !doPush) begin
        count_q <= count_q - 1'b1;
      end
      if (push_i && !doPush) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: one-cold row drive, per-key frame debounce, press
// pulses and a queued event stream. Define KEYPAD_RELEASE_EN to queue releases.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int ROW_CYCLES    = 250000,
  parameter int SAMPLE_OFFSET = 125000,
  parameter int DEBOUNCE      = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS-1:0]        col_in,
  output logic [ROWS-1:0]        row_out,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic [ROWS*COLS-1:0]   press_pulse,
  output logic                   frame_done,
  output logic                   overflow,
  keypad_matrix_scanner_if.master evt
);

  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = keyIdxWidth(ROWS, COLS);
  localparam int SLOT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]       colMeta_q;
  logic [COLS-1:0]       colSync_q;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ROWS-1:0]       rowOut_q;
  logic [31:0]           rowMaskAll;
  logic [KEYS-1:0]       raw_q, rawNow;
  logic [KEYS-1:0]       stable_q, stable_d;
  logic [KEYS-1:0]       pulse_q;
  logic [DB_W-1:0]       dbCnt_q [KEYS];
  logic [DB_W-1:0]       dbCnt_d [KEYS];
  logic [KEYS-1:0]       pendPress_q, pendPress_d;
  logic [KEYS-1:0]       pendRel_q, pendRel_d;
  logic [KEYS-1:0]       pendAny, selMask;
  logic                  selValid, selPress;
  logic [MAX_CODE_W-1:0] selIdx;
  logic                  pushValid_q;
  keyEvt_t               pushEvt_q;
  logic                  frameDone_q;
  logic                  slotWrap, frameEnd, sampleNow;
  keyEvt_t               head;
  logic                  fifoValid, fifoFull;
  logic                  unusedBits;

  assign slotWrap   = (slot_q == SLOT_W'(ROW_CYCLES - 1));
  assign frameEnd   = slotWrap && (row_q == ROW_W'(ROWS - 1));
  assign sampleNow  = (slot_q == SLOT_W'(SAMPLE_OFFSET));
  assign slot_d     = slotWrap ? '0 : slot_q + 1'b1;
  assign row_d      = frameEnd ? '0 : (slotWrap ? row_q + 1'b1 : row_q);
  assign rowMaskAll = rowMask(int'(row_d));
  assign pendAny    = pendPress_q | pendRel_q;

  // Merge the capture happening this cycle so a sample on the frame's last
  // cycle still feeds that frame's debounce decision.
  always_comb begin
    rawNow = raw_q;
    for (int k = 0; k < KEYS; k++) begin
      if (sampleNow && ((k / COLS) == int'(row_q))) begin
        rawNow[k] = ~colSync_q[k % COLS];
      end
    end
  end

  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < KEYS; k++) begin
      dbCnt_d[k] = dbCnt_q[k];
      if (frameEnd) begin
        if (rawNow[k] == stable_q[k]) begin
          dbCnt_d[k] = '0;
        end else if (dbCnt_q[k] == DB_W'(DEBOUNCE - 1)) begin
          stable_d[k] = ~stable_q[k];
          dbCnt_d[k]  = '0;
        end else begin
          dbCnt_d[k] = dbCnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Lowest pending key wins; for one key a press goes out before its release.
  always_comb begin
    selValid = 1'b0;
    selPress = 1'b0;
    selIdx   = '0;
    selMask  = '0;
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (pendAny[k]) begin
        selValid = 1'b1;
        selIdx   = MAX_CODE_W'(k);
        selPress = pendPress_q[k];
        selMask  = KEYS'(1) << k;
      end
    end
    pendPress_d = (pendPress_q & ~(selPress ? selMask : '0)) | (stable_d & ~stable_q);
    pendRel_d   = pendRel_q & ~(selPress ? '0 : selMask);
`ifdef KEYPAD_RELEASE_EN
    pendRel_d   = pendRel_d | (stable_q & ~stable_d);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colMeta_q   <= '1;
      colSync_q   <= '1;
      slot_q      <= '0;
      row_q       <= '0;
      rowOut_q    <= '1;
      raw_q       <= '0;
      stable_q    <= '0;
      pulse_q     <= '0;
      frameDone_q <= 1'b0;
      pendPress_q <= '0;
      pendRel_q   <= '0;
      pushValid_q <= 1'b0;
      pushEvt_q   <= '0;
      for (int k = 0; k < KEYS; k++) begin
        dbCnt_q[k] <= '0;
      end
    end else begin
      colMeta_q   <= col_in;
      colSync_q   <= colMeta_q;
      slot_q      <= slot_d;
      row_q       <= row_d;
      rowOut_q    <= rowMaskAll[ROWS-1:0];
      raw_q       <= rawNow;
      stable_q    <= stable_d;
      pulse_q     <= stable_d & ~stable_q;
      frameDone_q <= frameEnd;
      pendPress_q <= pendPress_d;
      pendRel_q   <= pendRel_d;
      pushValid_q <= selValid;
      pushEvt_q   <= '{code: selIdx, isRelease: selValid & ~selPress};
      for (int k = 0; k < KEYS; k++) begin
        dbCnt_q[k] <= dbCnt_d[k];
      end
    end
  end

  keypad_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (pushValid_q),
    .data_i    (pushEvt_q),
    .pop_i     (evt.evt_ready),
    .valid_o   (fifoValid),
    .full_o    (fifoFull),
    .head_o    (head),
    .overflow_o(overflow)
  );

  assign row_out       = rowOut_q;
  assign key_state     = stable_q;
  assign press_pulse   = pulse_q;
  assign frame_done    = frameDone_q;
  assign evt.evt_valid = fifoValid;
  assign evt.evt_code  = head.code[CODE_W-1:0];

`ifdef KEYPAD_RELEASE_EN
  assign evt.evt_release = head.isRelease;
  assign unusedBits      = ^{rowMaskAll[31:ROWS], head.code[MAX_CODE_W-1:CODE_W], fifoFull};
`else
  assign evt.evt_release = 1'b0;
  assign unusedBits      = ^{rowMaskAll[31:ROWS], head.code[MAX_CODE_W-1:CODE_W], fifoFull,
                             head.isRelease};
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a physical keypad model drives col_in and a
// frame-level reference model is compared with the outputs every cycle.
module tb_keypad_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEYS  = ROWS * COLS;
  localparam int RC    = 16;
  localparam int SO    = 8;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = ROWS * RC;

  typedef struct {
    int t;
    int code;
    bit rel;
  } sched_t;

  typedef struct {
    int code;
    bit rel;
  } mevt_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic [KEYS-1:0] key_state;
  logic [KEYS-1:0] press_pulse;
  logic            frame_done;
  logic            overflow;
  logic            evtReady = 1'b1;
  logic [KEYS-1:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  sched_t      schedQ[$];
  mevt_t       fifoQ[$];
  bit [KEYS-1:0] mRaw;
  bit [KEYS-1:0] mStable;
  bit [KEYS-1:0] expPulse;
  int          mCnt [KEYS];
  int          n;
  bit          mOverflow;
  int          lastCode;
  bit          lastRel;

  keypad_matrix_scanner_if #(.CODE_W(4)) evtIf ();
  assign evtIf.evt_ready = evtReady;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .ROW_CYCLES(RC), .SAMPLE_OFFSET(SO),
    .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
    .key_state(key_state), .press_pulse(press_pulse), .frame_done(frame_done),
    .overflow(overflow), .evt(evtIf)
  );

  initial forever #5 clk = ~clk;

  // A pressed key shorts its column to its row; only a driven-low row pulls low.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      col_in[c] = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
        if (!row_out[r] && pressed[r*COLS+c]) col_in[c] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [KEYS-1:0] keys);
    pressed = keys;
  endtask

  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) seen = 1'b1;
    end
    checkOutput("frameTimeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic modelReset();
    schedQ.delete();
    fifoQ.delete();
    mRaw = '0; mStable = '0; expPulse = '0;
    for (int k = 0; k < KEYS; k++) mCnt[k] = 0;
    n = 0; mOverflow = 1'b0; lastCode = 0; lastRel = 1'b0;
  endtask

  task automatic compareAll();
    int rowExp;
    rowExp = (n == 0) ? 15 : (15 ^ (1 << ((n / RC) % ROWS)));
    checkOutput("row_out", 32'(row_out), 32'(rowExp));
    checkOutput("key_state", 32'(key_state), 32'(mStable));
    checkOutput("press_pulse", 32'(press_pulse), 32'(expPulse));
    checkOutput("frame_done", 32'(frame_done), (n > 0 && n % FRAME == 0) ? 32'd1 : 32'd0);
    checkOutput("evt_valid", 32'(evtIf.evt_valid), (fifoQ.size() > 0) ? 32'd1 : 32'd0);
    checkOutput("evt_code", 32'(evtIf.evt_code), 32'((fifoQ.size() > 0) ? fifoQ[0].code : lastCode));
    checkOutput("evt_release", 32'(evtIf.evt_release), 32'((fifoQ.size() > 0) ? fifoQ[0].rel : lastRel));
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
  endtask

  // Advance the model across the next rising edge using the current inputs.
  task automatic stepModel();
    int m;
    int rank;
    bit popped;
    m = n + 1;
    if (n % RC == SO) begin
      for (int c = 0; c < COLS; c++) mRaw[((n / RC) % ROWS) * COLS + c] = pressed[((n / RC) % ROWS) * COLS + c];
    end
    expPulse = '0;
    if (m % FRAME == 0) begin
      rank = 0;
      for (int k = 0; k < KEYS; k++) begin
        if (mRaw[k] == mStable[k]) begin
          mCnt[k] = 0;
        end else begin
          mCnt[k]++;
          if (mCnt[k] >= DEB) begin
            mCnt[k] = 0;
            mStable[k] = ~mStable[k];
            if (mStable[k]) begin
              expPulse[k] = 1'b1;
              schedQ.push_back('{m + 2 + rank, k, 1'b0});
              rank++;
            end else begin
`ifdef KEYPAD_RELEASE_EN
              schedQ.push_back('{m + 2 + rank, k, 1'b1});
              rank++;
`endif
            end
          end
        end
      end
    end
    popped = 1'b0;
    if (fifoQ.size() > 0 && evtReady) begin
      lastCode = fifoQ[0].code;
      lastRel  = fifoQ[0].rel;
      void'(fifoQ.pop_front());
      popped = 1'b1;
    end
    if (schedQ.size() > 0 && schedQ[0].t == m) begin
      sched_t s;
      s = schedQ.pop_front();
      if (fifoQ.size() < DEPTH) fifoQ.push_back('{s.code, s.rel});
      else mOverflow = 1'b1;
    end
    n = m;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      modelReset();
    end else begin
      compareAll();
      stepModel();
    end
  end

  initial begin
    rst = 1'b0;
    evtReady = 1'b1;
    applyStimulus('0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset row_out", 32'(row_out), 32'hF);
    checkOutput("reset key_state", 32'(key_state), 32'h0);
    checkOutput("reset evt_valid", 32'(evtIf.evt_valid), 32'h0);
    checkOutput("reset frame_done", 32'(frame_done), 32'h0);
    rst = 1'b1;

    // Single key 6 held for three frames, then released.
    waitFrame();
    applyStimulus(16'h0040);
    waitFrame();
    checkOutput("key6 after 1 frame", 32'(key_state), 32'h0);
    waitFrame();
    checkOutput("key6 stable", 32'(key_state), 32'h0040);
    checkOutput("key6 pulse", 32'(press_pulse), 32'h0040);
    @(posedge clk); #1;
    checkOutput("key6 pulse ends", 32'(press_pulse), 32'h0);
    @(posedge clk); #1;
    checkOutput("key6 evt_valid", 32'(evtIf.evt_valid), 32'h1);
    checkOutput("key6 evt_code", 32'(evtIf.evt_code), 32'd6);
    checkOutput("key6 evt_release", 32'(evtIf.evt_release), 32'h0);
    waitFrame();
    applyStimulus('0);
    waitFrame();
    waitFrame();
    checkOutput("key6 released", 32'(key_state), 32'h0);

    // One-frame glitch never reaches the stable map.
    applyStimulus(16'h0040);
    waitFrame();
    applyStimulus('0);
    waitFrame();
    waitFrame();
    checkOutput("glitch ignored", 32'(key_state), 32'h0);

    // Keys 0, 5, 15 together come out in ascending order.
    applyStimulus(16'h8021);
    waitFrame();
    waitFrame();
    checkOutput("multi stable", 32'(key_state), 32'h8021);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("multi code0", 32'(evtIf.evt_code), 32'd0);
    @(posedge clk); #1;
    checkOutput("multi code5", 32'(evtIf.evt_code), 32'd5);
    @(posedge clk); #1;
    checkOutput("multi code15", 32'(evtIf.evt_code), 32'd15);
    @(posedge clk); #1;
    checkOutput("multi drained", 32'(evtIf.evt_valid), 32'h0);
    waitFrame();
    applyStimulus('0);
    waitFrame();
    waitFrame();

    // Five presses with the consumer stalled: four held, one dropped.
    evtReady = 1'b0;
    applyStimulus(16'h0006);
    waitFrame();
    applyStimulus(16'h009E);
    waitFrame();
    waitFrame();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stall overflow", 32'(overflow), 32'h1);
    checkOutput("stall head", 32'(evtIf.evt_code), 32'd1);
    evtReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall drained", 32'(evtIf.evt_valid), 32'h0);
    checkOutput("stall hold code", 32'(evtIf.evt_code), 32'd4);
    applyStimulus('0);
    repeat (3) waitFrame();

    // Reset mid-frame with an event waiting.
    evtReady = 1'b0;
    applyStimulus(16'h0200);
    waitFrame();
    waitFrame();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre-reset evt_valid", 32'(evtIf.evt_valid), 32'h1);
    checkOutput("pre-reset evt_code", 32'(evtIf.evt_code), 32'd9);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset row_out", 32'(row_out), 32'hF);
    checkOutput("midreset key_state", 32'(key_state), 32'h0);
    checkOutput("midreset evt_valid", 32'(evtIf.evt_valid), 32'h0);
    checkOutput("midreset overflow", 32'(overflow), 32'h0);
    applyStimulus('0);
    evtReady = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Random key patterns per frame with a randomly stalling consumer.
    waitFrame();
    for (int f = 0; f < 16; f++) begin
      applyStimulus(pressed ^ 16'($urandom() & $urandom()));
      for (int i = 0; i < FRAME; i++) begin
        @(posedge clk);
        #1;
        evtReady = ($urandom_range(0, 3) != 0);
      end
    end
    applyStimulus('0);
    evtReady = 1'b1;
    repeat (4) waitFrame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised matrix-keypad scanner for the whack-a-mole input path: one-cold row drive, synchronised and per-key debounced column sampling, and a debounced key map. It emits one-cycle press pulses and queues key events in a small valid/ready FIFO for the game FSM. It runs entirely on `clk`, with no secondary scan clock.

## Interface
- `ROWS`, default 4: number of row lines driven.
- `COLS`, default 4: number of column lines sampled.
- `ROW_CYCLES`, default 250000: clk cycles per row slot (5 ms at 50 MHz).
- `SAMPLE_OFFSET`, default 125000: cycle within a slot at which columns are captured; legal range is 2 to ROW_CYCLES-1.
- `DEBOUNCE`, default 2: consecutive frames a key must disagree with its stable state before the stable state changes; minimum 1.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `col_in`, in, COLS: column inputs, active-low, asynchronous to `clk`.
- `row_out`, out, ROWS: row drive, one-cold; the active row is low.
- `key_state`, out, ROWS*COLS: debounced pressed map; bit index = row*COLS+col.
- `press_pulse`, out, ROWS*COLS: one-cycle pulse per key on a stable 0→1 transition.
- `frame_done`, out, 1: one-cycle pulse at the end of each full scan frame.
- `evt_valid`, out, 1: FIFO head is valid.
- `evt_ready`, in, 1: consumer accepts the head.
- `evt_code`, out, clog2(ROWS*COLS): key index of the head event.
- `evt_release`, out, 1: head event is a release.
- `overflow`, out, 1: sticky; an event was dropped.

## Operation
- `col_in` passes through a 2-flop synchroniser and is inverted, so pressed reads as 1.
- A slot counter runs 0..ROW_CYCLES-1, and a row index runs 0..ROWS-1, advancing when the slot counter wraps.
- `row_out` is registered as ~(1<<row).
- At slot count == SAMPLE_OFFSET, the synchronised columns are written into `raw[row]`.
- When the last slot of the last row completes, `frame_done` pulses and the debounce update runs on all keys in parallel:
  - If `raw` equals stable, the key's counter clears.
  - Otherwise the counter increments. On reaching DEBOUNCE, stable flips and the counter clears.
- Keys whose stable state went 0→1 set a `press_pulse` bit and a pending-press bit.
- Pending bits are serialised lowest index first, at one FIFO push per cycle.
  - Constraint: ROWS*ROW_CYCLES ≥ 2*ROWS*COLS, so serialisation always finishes within a frame.
- FIFO behaviour:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set; it clears only on reset.
  - A pop occurs when `evt_valid` and `evt_ready` are both high.
  - When the FIFO is empty, `evt_valid`=0 and `evt_code`/`evt_release` hold their last values.
- Simultaneous key changes in one frame produce events in ascending index order.

## Timing
- Reset values:
  - `row_out` = all ones.
  - `key_state`, `press_pulse`, `frame_done`, `evt_valid`, `overflow` = 0.
  - Counters, `raw`, debounce counters and pending bits = 0; FIFO empty.
- The first edge after reset release drives row 0 low.
- `key_state` and `press_pulse` update on the cycle after the frame's last slot cycle, in the same cycle as `frame_done`. `press_pulse` lasts exactly one cycle.
- Event latency: the key with rank r among the pending keys (r=0 is the lowest index) reaches `evt_valid` r+2 cycles after `frame_done`, provided the FIFO is not full.
- Minimum latency from a press to `key_state` is DEBOUNCE frames.
- Reset asserted mid-frame or mid-serialisation discards all state immediately.

## Configuration
- `KEYPAD_RELEASE_EN` defined: stable 1→0 transitions also set pending bits and are queued with `evt_release`=1. When a key has both a press and a release pending in the same frame, which is only possible for DEBOUNCE=1 glitches across frames, the press is queued first.
- `KEYPAD_RELEASE_EN` undefined: releases update `key_state` only and are never queued; `evt_release` is tied to 0.

## Structure
- Package `keypad_pkg` holds:
  - The key-index width function clog2(ROWS*COLS).
  - The event typedef `{code, release}`.
  - The row-mask helper.
- Sub-module `keypad_evt_fifo` is a parametrised synchronous valid/ready FIFO with a full/empty flag and push-while-full-with-pop support.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, ROW_CYCLES=16, SAMPLE_OFFSET=8, DEBOUNCE=2, FIFO_DEPTH=4, `evt_ready`=1 unless stated.
- Hold `col_in`[2] low whenever row 1 is active, for 3 frames → `key_state`[6]=1 after the 2nd `frame_done`, `press_pulse`[6] high for 1 cycle, one event with code 6 and release=0.
- Key 6 pressed for 1 frame only → `key_state` stays 0, no pulse, no event.
- Keys 0, 5 and 15 pressed in the same frames → events 0, 5, 15 on consecutive accepted cycles, starting 2 cycles after `frame_done`.
- `evt_ready`=0 while 5 distinct keys are pressed across frames → 4 entries held, `overflow`=1, the fifth is dropped. Raising `evt_ready` then drains the entries in order.
- Release key 6 after a debounced press → with `KEYPAD_RELEASE_EN`, an event with code 6 and release=1 after DEBOUNCE frames; without it, no event and `key_state`[6]=0.
- Assert `rst` mid-frame with the FIFO non-empty → `row_out`=1111, `key_state`=0, `evt_valid`=0, `overflow`=0 immediately.
